// File: rtl/uart_pkg.sv
// uart_pkg: types, constants and helpers shared by the UART transmit and receive paths
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
    localparam int UART_DATA_BITS = 8;
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: user-side byte send handshake plus the serial line
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;
    logic       tx_done;
    logic       tx;
    modport master (output tx_data, tx_send, input tx_busy, tx_done, tx);
    modport slave  (input tx_data, tx_send, output tx_busy, tx_done, tx);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter producing one tick per CLKS_PER_BIT enabled cycles
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic bit_tick
);
    localparam int W = CLKS_PER_BIT > 2 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign bit_tick = en && cnt_q == LAST;
    // clear realigns the bit phase to a new request; otherwise wrap at the terminal count
    always_comb cnt_d = clear ? '0 : !en ? cnt_q : bit_tick ? '0 : cnt_q + W'(1);
    // counter register
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter serializing one accepted byte onto the tx pin, LSB first
module uart_tx import uart_pkg::*; #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input logic       clk,
    input logic       rst,
    uart_tx_if.slave  bus
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    uart_tx_state_t state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic       tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic       accept, bit_tick;
    assign accept = state_q == IDLE && bus.tx_send;
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .en       (busy_q),
        .bit_tick (bit_tick)
    );
    // next-state and next-output logic; every output is computed here and registered below
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.tx_send) begin
                state_d = START;
                shift_d = bus.tx_data;
                bit_d   = '0;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
            end
            START: if (bit_tick) begin
                state_d = DATA;
                tx_d    = shift_q[0];
            end
            DATA: if (bit_tick) begin
                if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                end
            end
            STOP: if (bit_tick) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and output registers; reset drops the line high at once, aborting any frame
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of the 8N1 transmitter at 10 and 2 clocks per bit
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] data = 8'h00;
    logic       sel = 1'b0;
    int         checks = 0;
    int         failures = 0;
    uart_tx_if ifa ();
    uart_tx_if ifb ();
    assign ifa.tx_send = send & ~sel;
    assign ifb.tx_send = send & sel;
    assign ifa.tx_data = data;
    assign ifb.tx_data = data;
    logic tx_s, busy_s, done_s;
    assign tx_s   = sel ? ifb.tx : ifa.tx;
    assign busy_s = sel ? ifb.tx_busy : ifa.tx_busy;
    assign done_s = sel ? ifb.tx_done : ifa.tx_done;
    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(500_000)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"}, tx_s, 1'b1);
        chk({tag, "_busy"}, busy_s, 1'b0);
        chk({tag, "_done"}, done_s, 1'b0);
    endtask

    // called one step after the accept edge; ends in the tx_done cycle
    task automatic run_frame(input string tag, input int cpb, input logic [7:0] d, input bit disturb);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        for (int i = 0; i < 10 * cpb; i++) begin
            if (disturb && i == 4 * cpb) begin
                send = 1'b1;
                data = 8'hFF;
            end
            if (disturb && i == 4 * cpb + 1) begin
                send = 1'b0;
                data = 8'h00;
            end
            chk({tag, "_tx"}, tx_s, fr[i / cpb]);
            chk({tag, "_busy"}, busy_s, 1'b1);
            chk({tag, "_done"}, done_s, 1'b0);
            step();
        end
        chk({tag, "_end_tx"}, tx_s, 1'b1);
        chk({tag, "_end_busy"}, busy_s, 1'b0);
        chk({tag, "_end_done"}, done_s, 1'b1);
    endtask

    initial begin
        step();
        chk_idle("reset");
        send = 1'b1;
        repeat (3) begin
            step();
            chk_idle("s1_rst_send");
        end
        send = 1'b0;
        rst = 1'b0;
        step();
        chk_idle("s1_release");
        step();
        data = 8'hA5;
        send = 1'b1;
        step();
        send = 1'b0;
        run_frame("s2_a5", 10, 8'hA5, 1'b0);
        step();
        chk_idle("s2_after");
        data = 8'hA5;
        send = 1'b1;
        step();
        send = 1'b0;
        run_frame("s3_a5", 10, 8'hA5, 1'b1);
        repeat (15) begin
            step();
            chk_idle("s3_no_second");
        end
        data = 8'h00;
        send = 1'b1;
        step();
        run_frame("s4_00", 10, 8'h00, 1'b0);
        data = 8'hFF;
        step();
        send = 1'b0;
        run_frame("s4_ff", 10, 8'hFF, 1'b0);
        step();
        chk_idle("s4_after");
        data = 8'h3C;
        send = 1'b1;
        step();
        send = 1'b0;
        data = 8'h00;
        for (int i = 0; i < 53; i++) begin
            chk("s5_pre_busy", busy_s, 1'b1);
            step();
        end
        chk("s5_bit4", tx_s, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("s5_async_rst");
        step();
        rst = 1'b0;
        chk_idle("s5_in_rst");
        step();
        chk_idle("s5_released");
        data = 8'h3C;
        send = 1'b1;
        step();
        send = 1'b0;
        run_frame("s5_3c", 10, 8'h3C, 1'b0);
        step();
        sel = 1'b1;
        chk_idle("s6_idle");
        data = 8'h81;
        send = 1'b1;
        step();
        send = 1'b0;
        run_frame("s6_81", 2, 8'h81, 1'b0);
        step();
        chk_idle("s6_after");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
